boot_loader: RTL and testbench
==============================

Name: boot_loader

Overview:
- Power-on program loader that sits upstream of the IM1/DM1 SRAM wrappers inside top.
- After reset it copies a program image, one 32-bit word per cycle, from a read-only boot store into instruction SRAM and then data SRAM.
- It holds the CPU stalled until the copy completes, replacing the simulation-only hierarchical preload with synthesizable hardware.
- Image layout matches the main0..3.hex split:
  - boot words [0, IM_WORDS) go to IM addresses 0..IM_WORDS-1.
  - boot words [IM_WORDS, IM_WORDS+DM_WORDS) go to DM addresses 0..DM_WORDS-1.

Parameters:
IM_WORDS, 16384, number of words copied into IM (power of 2)
DM_WORDS, 16384, number of words copied into DM (power of 2)
SRAM_AW, 14, SRAM word address width (log2 of max(IM_WORDS, DM_WORDS))
ROM_AW, 15, boot store word address width (log2 of IM_WORDS+DM_WORDS)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-low reset (0 = reset)
boot_en  input  1  sampled in IDLE; 1 = perform copy, 0 = skip straight to DONE
rom_en  output  1  boot store read enable
rom_addr  output  ROM_AW  boot store word address
rom_rdata  input  32  boot store data, valid exactly 1 cycle after rom_en
im_web  output  4  IM byte write enables, active low (4'b0000 = write word)
im_a  output  SRAM_AW  IM word address
im_di  output  32  IM write data
dm_web  output  4  DM byte write enables, active low
dm_a  output  SRAM_AW  DM word address
dm_di  output  32  DM write data
cpu_hold  output  1  1 = CPU must stall; deasserts only in DONE
done  output  1  1 = copy complete (or skipped)
checksum  output  32  modulo-2^32 sum of every word written

Behaviour:
- Reset (rst==0 at a rising edge): state=IDLE, counter=0, write-pending flag=0, checksum=0.
- Output values during reset:
  - rom_en=0, rom_addr=0.
  - im_web=dm_web=4'b1111, im_a=dm_a=0.
  - cpu_hold=1, done=0.
- States: IDLE, LOAD, DRAIN, DONE. Let N = IM_WORDS+DM_WORDS.
- IDLE (exactly one cycle after reset release):
  - boot_en=1: next state LOAD, cnt=0.
  - boot_en=0: next state DONE.
- LOAD:
  - rom_en=1, rom_addr=cnt.
  - Each cycle: wr_pend<=1, wr_idx<=cnt, cnt<=cnt+1.
  - When cnt==N-1, next state DRAIN.
- DRAIN: rom_en=0, wr_pend<=0; next state DONE.
- DONE:
  - Terminal until reset. cpu_hold=0, done=1, rom_en=0, both web=4'b1111.
- Write path (combinational from registered wr_pend/wr_idx and live rom_rdata):
  - wr_idx<IM_WORDS: im_web=4'b0000, im_a=wr_idx[SRAM_AW-1:0], im_di=rom_rdata.
  - Otherwise: dm_web=4'b0000, dm_a=wr_idx-IM_WORDS, dm_di=rom_rdata.
  - Never both webs low in one cycle; im_di/dm_di don't-care when not writing.
- Checksum:
  - checksum<=checksum+rom_rdata on every cycle with wr_pend=1; carry discarded.
  - Holds its final value in DONE.
- Latency: with boot_en=1, the first write occurs 2 cycles after reset release, the last write in cycle N+1, and done=1 from cycle N+2 (cycle 0 = first cycle with rst=1).
- Address wrap: cnt is ROM_AW+1 bits wide, so no overflow occurs at N-1.
- Reset mid-copy: aborts immediately. Any in-flight write is suppressed (webs forced high that cycle). Copy restarts from word 0 after release, and checksum is cleared.
- boot_en is ignored outside IDLE.
- rom_rdata is not inspected when wr_pend=0.

Test Plan:
- IM_WORDS=DM_WORDS=4, rom[k]=32'h1000_0000+k, boot_en=1 -> rom_en high cycles 1..8 (addr 0..7), with these required writes:
  - IM writes cycles 2..5 at A=0..3 with 32'h1000_0000..32'h1000_0003.
  - DM writes cycles 6..9 at A=0..3 with 32'h1000_0004..32'h1000_0007.
  - done=1, cpu_hold=0 from cycle 10; checksum=32'h8000_001C.
- Same config, boot_en=0 at cycle 0 -> no rom_en, no writes ever; done=1 from cycle 1; checksum=0.
- Same config, rst driven 0 during cycle 4 -> webs 4'b1111 that cycle; after release, the sequence restarts with the IM write of word 0 two cycles later; final checksum is as in scenario 1.
- rom[k]=32'hFFFF_FFFF for all 8 words -> checksum=32'hFFFF_FFF8 (wrap discarded carry); every write uses web=4'b0000 with data FFFF_FFFF.
- Default parameters, rom[k]=k -> 32768 writes; IM[16383]=16383 and DM[0]=16384; done asserted at cycle 32770; checksum=32'h1FFF_C000.
- Assertion check across all runs -> im_web and dm_web never both 4'b0000 in the same cycle; cpu_hold==!done at all times.

Source files
------------

// File: rtl/boot_loader.sv
// Power-on loader: streams a boot-store image into IM then DM one word per
// cycle, holding the CPU stalled until the copy is complete.
module boot_loader #(
  parameter int IM_WORDS = 16384,
  parameter int DM_WORDS = 16384,
  parameter int SRAM_AW  = 14,
  parameter int ROM_AW   = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               boot_en,
  output logic               rom_en,
  output logic [ROM_AW-1:0]  rom_addr,
  input  logic [31:0]        rom_rdata,
  output logic [3:0]         im_web,
  output logic [SRAM_AW-1:0] im_a,
  output logic [31:0]        im_di,
  output logic [3:0]         dm_web,
  output logic [SRAM_AW-1:0] dm_a,
  output logic [31:0]        dm_di,
  output logic               cpu_hold,
  output logic               done,
  output logic [31:0]        checksum
);
  localparam int N  = IM_WORDS + DM_WORDS;
  localparam int CW = ROM_AW + 1;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, wr_idx, dm_off;
  logic          wr_pend, wr_im, wr_dm;
  logic [31:0]   sum;
  logic          unused_dm_hi;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      wr_idx  <= '0;
      wr_pend <= 1'b0;
      sum     <= '0;
    end else begin
      state <= state_nx;
      // rom_rdata belongs to the word fetched last cycle, tracked by wr_idx
      if (wr_pend) sum <= sum + rom_rdata;
      case (state)
        IDLE: begin
          cnt     <= '0;
          wr_pend <= 1'b0;
        end
        LOAD: begin
          wr_pend <= 1'b1;
          wr_idx  <= cnt;
          cnt     <= cnt + 1'b1;
        end
        default: wr_pend <= 1'b0;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = boot_en ? LOAD : DONE;
      LOAD:    if (cnt == CW'(N - 1)) state_nx = DRAIN;
      DRAIN:   state_nx = DONE;
      default: state_nx = DONE;
    endcase
  end

  // Every strobe is gated by rst so a reset mid-copy kills the in-flight write
  assign rom_en   = rst && (state == LOAD);
  assign rom_addr = rom_en ? cnt[ROM_AW-1:0] : '0;

  assign dm_off = wr_idx - CW'(IM_WORDS);
  assign wr_im  = rst && wr_pend && (wr_idx < CW'(IM_WORDS));
  assign wr_dm  = rst && wr_pend && !(wr_idx < CW'(IM_WORDS));

  assign im_web = wr_im ? 4'b0000 : 4'b1111;
  assign im_a   = wr_im ? wr_idx[SRAM_AW-1:0] : '0;
  assign im_di  = rom_rdata;
  assign dm_web = wr_dm ? 4'b0000 : 4'b1111;
  assign dm_a   = wr_dm ? dm_off[SRAM_AW-1:0] : '0;
  assign dm_di  = rom_rdata;

  assign done     = rst && (state == DONE);
  assign cpu_hold = !done;
  assign checksum = sum;

  assign unused_dm_hi = ^dm_off[CW-1:SRAM_AW];
endmodule

// File: tb/tb_boot_loader.sv
// Directed bench: small 4+4 image for cycle-exact checks, default size for the full copy.
module tb_boot_loader;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // small instance: IM_WORDS=DM_WORDS=4
  logic        s_rst, s_boot, s_rom_en, s_done, s_hold;
  logic [2:0]  s_rom_addr;
  logic [31:0] s_rdata, s_im_di, s_dm_di, s_ck;
  logic [3:0]  s_im_web, s_dm_web;
  logic [1:0]  s_im_a, s_dm_a;
  logic [31:0] s_rom [8];

  boot_loader #(.IM_WORDS(4), .DM_WORDS(4), .SRAM_AW(2), .ROM_AW(3)) u_small (
    .clk(clk), .rst(s_rst), .boot_en(s_boot),
    .rom_en(s_rom_en), .rom_addr(s_rom_addr), .rom_rdata(s_rdata),
    .im_web(s_im_web), .im_a(s_im_a), .im_di(s_im_di),
    .dm_web(s_dm_web), .dm_a(s_dm_a), .dm_di(s_dm_di),
    .cpu_hold(s_hold), .done(s_done), .checksum(s_ck)
  );

  always @(posedge clk) if (s_rom_en) s_rdata <= s_rom[s_rom_addr];

  // default-size instance, rom[k] = k
  logic        b_rst, b_boot, b_rom_en, b_done, b_hold;
  logic [14:0] b_rom_addr;
  logic [31:0] b_rdata, b_im_di, b_dm_di, b_ck;
  logic [3:0]  b_im_web, b_dm_web;
  logic [13:0] b_im_a, b_dm_a;

  boot_loader u_big (
    .clk(clk), .rst(b_rst), .boot_en(b_boot),
    .rom_en(b_rom_en), .rom_addr(b_rom_addr), .rom_rdata(b_rdata),
    .im_web(b_im_web), .im_a(b_im_a), .im_di(b_im_di),
    .dm_web(b_dm_web), .dm_a(b_dm_a), .dm_di(b_dm_di),
    .cpu_hold(b_hold), .done(b_done), .checksum(b_ck)
  );

  always @(posedge clk) if (b_rom_en) b_rdata <= {17'd0, b_rom_addr};

  logic [31:0] im_last  = 32'hDEAD_BEEF;
  logic [31:0] dm_first = 32'hDEAD_BEEF;
  int          n_wr     = 0;

  always @(negedge clk) begin
    if (b_im_web == 4'b0000) n_wr++;
    if (b_dm_web == 4'b0000) n_wr++;
    if (b_im_web == 4'b0000 && b_im_a == 14'h3FFF) im_last  = b_im_di;
    if (b_dm_web == 4'b0000 && b_dm_a == 14'h0000) dm_first = b_dm_di;
  end

  // Invariants on both instances, every cycle
  always @(negedge clk) begin
    total += 4;
    assert (!(s_im_web == 4'b0000 && s_dm_web == 4'b0000)) else begin
      bad++; $error("FAIL s_web_excl im=%b dm=%b", s_im_web, s_dm_web);
    end
    assert (s_hold === !s_done) else begin
      bad++; $error("FAIL s_hold_inv hold=%b done=%b", s_hold, s_done);
    end
    assert (!(b_im_web == 4'b0000 && b_dm_web == 4'b0000)) else begin
      bad++; $error("FAIL b_web_excl im=%b dm=%b", b_im_web, b_dm_web);
    end
    assert (b_hold === !b_done) else begin
      bad++; $error("FAIL b_hold_inv hold=%b done=%b", b_hold, b_done);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] dat(input bit ff, input int k);
    return ff ? 32'hFFFF_FFFF : 32'h1000_0000 + 32'(k);
  endfunction

  // Entered at the start of cycle 0 (rst just released, boot_en=1)
  task automatic run_load(input bit ff, input logic [31:0] exp_ck);
    for (int c = 0; c < 12; c++) begin
      bit en, iw, dw;
      @(negedge clk);
      en = (c >= 1 && c <= 8);
      iw = (c >= 2 && c <= 5);
      dw = (c >= 6 && c <= 9);
      chk($sformatf("rom_en c%0d", c), {31'd0, s_rom_en}, {31'd0, en});
      if (en) chk($sformatf("rom_addr c%0d", c), {29'd0, s_rom_addr}, 32'(c - 1));
      chk($sformatf("im_web c%0d", c), {28'd0, s_im_web}, iw ? 32'h0 : 32'hF);
      chk($sformatf("dm_web c%0d", c), {28'd0, s_dm_web}, dw ? 32'h0 : 32'hF);
      if (iw) begin
        chk($sformatf("im_a c%0d", c), {30'd0, s_im_a}, 32'(c - 2));
        chk($sformatf("im_di c%0d", c), s_im_di, dat(ff, c - 2));
      end
      if (dw) begin
        chk($sformatf("dm_a c%0d", c), {30'd0, s_dm_a}, 32'(c - 6));
        chk($sformatf("dm_di c%0d", c), s_dm_di, dat(ff, c - 2));
      end
      chk($sformatf("done c%0d", c), {31'd0, s_done}, {31'd0, c >= 10});
      chk($sformatf("hold c%0d", c), {31'd0, s_hold}, {31'd0, c < 10});
      if (c == 2)  chk("ck_start", s_ck, 32'h0);
      if (c == 11) chk("ck_final", s_ck, exp_ck);
      cyc();
    end
  endtask

  initial begin
    int c;
    s_rst = 1'b0; s_boot = 1'b1;
    b_rst = 1'b0; b_boot = 1'b1;
    for (int k = 0; k < 8; k++) s_rom[k] = dat(1'b0, k);
    repeat (2) cyc();

    // reset state
    @(negedge clk);
    chk("rst rom_en",   {31'd0, s_rom_en}, 32'h0);
    chk("rst rom_addr", {29'd0, s_rom_addr}, 32'h0);
    chk("rst im_web",   {28'd0, s_im_web}, 32'hF);
    chk("rst dm_web",   {28'd0, s_dm_web}, 32'hF);
    chk("rst im_a",     {30'd0, s_im_a}, 32'h0);
    chk("rst dm_a",     {30'd0, s_dm_a}, 32'h0);
    chk("rst hold",     {31'd0, s_hold}, 32'h1);
    chk("rst done",     {31'd0, s_done}, 32'h0);
    chk("rst ck",       s_ck, 32'h0);
    chk("rst b_ck",     b_ck, 32'h0);

    // 1: normal copy
    cyc(); s_rst = 1'b1;
    run_load(1'b0, 32'h8000_001C);

    // 2: boot_en=0 skips the copy
    s_rst = 1'b0; s_boot = 1'b0;
    cyc(); s_rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("skip rom_en c%0d", i), {31'd0, s_rom_en}, 32'h0);
      chk($sformatf("skip im_web c%0d", i), {28'd0, s_im_web}, 32'hF);
      chk($sformatf("skip dm_web c%0d", i), {28'd0, s_dm_web}, 32'hF);
      chk($sformatf("skip done c%0d", i), {31'd0, s_done}, {31'd0, i >= 1});
      chk($sformatf("skip ck c%0d", i), s_ck, 32'h0);
      cyc();
    end
    s_boot = 1'b1;

    // 3: reset during cycle 4 aborts the in-flight IM write, then restarts
    s_rst = 1'b0;
    cyc(); s_rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("pre im_web c%0d", i), {28'd0, s_im_web}, (i >= 2) ? 32'h0 : 32'hF);
      cyc();
    end
    s_rst = 1'b0;
    @(negedge clk);
    chk("abort im_web", {28'd0, s_im_web}, 32'hF);
    chk("abort dm_web", {28'd0, s_dm_web}, 32'hF);
    chk("abort rom_en", {31'd0, s_rom_en}, 32'h0);
    chk("abort hold",   {31'd0, s_hold}, 32'h1);
    cyc(); s_rst = 1'b1;
    run_load(1'b0, 32'h8000_001C);

    // 4: all-ones image wraps the checksum
    s_rst = 1'b0;
    for (int k = 0; k < 8; k++) s_rom[k] = dat(1'b1, k);
    cyc(); s_rst = 1'b1;
    run_load(1'b1, 32'hFFFF_FFF8);

    // 5: default-size full copy
    b_rst = 1'b1;
    c = 0;
    while (c < 40000) begin
      @(negedge clk);
      if (b_done) break;
      c++;
      cyc();
    end
    chk("big done_cycle", 32'(c), 32'd32770);
    chk("big n_writes",   32'(n_wr), 32'd32768);
    chk("big im_last",    im_last, 32'd16383);
    chk("big dm_first",   dm_first, 32'd16384);
    chk("big checksum",   b_ck, 32'h1FFF_C000);
    chk("big hold",       {31'd0, b_hold}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
